temp_seq_ctrl: RTL and testbench
================================

# temp_seq_ctrl

Multi-channel successor to the single-sensor load/compare controller. It sequences NUM_CH temperature sensors round-robin: it waits for the selected channel's ready flag, then pulses load and compare_data for one cycle each, and advances to the next channel. It sits between the sensor interfaces and the threshold-compare datapath, and drives the channel mux select. A per-channel watchdog skips sensors that never report.

## Interface
- NUM_CH, 4, number of sensor channels (2..16)
- TIMEOUT_CYCLES, 1024, WAIT cycles before a channel is declared dead (>=2)
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = run sweeps, 0 = stop at next safe point
- temp_ready  in  NUM_CH  per-channel conversion-done flag, level, sampled only for the selected channel in WAIT
- ch_sel  out  $clog2(NUM_CH)  channel currently served; drives data mux
- load  out  1  one-cycle pulse: capture sensor value of ch_sel
- compare_data  out  1  one-cycle pulse: compare captured value
- sweep_done  out  1  one-cycle pulse, coincident with compare_data on channel NUM_CH-1
- timeout_err  out  1  one-cycle pulse when the channel in ch_sel times out
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, WAIT, LOAD, COMPARE. Outputs are decoded from the registered state and channel, never from inputs.
- IDLE: if enable=1, go to WAIT; ch_sel holds.
- WAIT:
  - If enable=0, go to IDLE. ch_sel holds and the counter clears.
  - Else if temp_ready[ch_sel]=1, go to LOAD.
  - Else, with timeout compiled in, increment the watchdog counter. When counter = TIMEOUT_CYCLES-1, pulse timeout_err next cycle, advance ch_sel, clear the counter, and stay in WAIT.
  - enable=0 has priority over ready.
- LOAD: load=1. Go to COMPARE unconditionally (enable ignored).
- COMPARE: compare_data=1. sweep_done=1 if ch_sel=NUM_CH-1. Advance ch_sel. Go to WAIT if enable=1, else IDLE.
- Channel advance: ch_sel+1, wrapping NUM_CH-1 -> 0. The wrap works for non-power-of-two NUM_CH.
- The watchdog counter is $clog2(TIMEOUT_CYCLES) bits wide and clears on every entry to WAIT.
- temp_ready of non-selected channels, and of any channel outside WAIT, is ignored and not latched.
- Unreachable state encodings recover to IDLE on the next edge.

## Timing
- Reset values: state=IDLE, ch_sel=0, counter=0, load=0, compare_data=0, sweep_done=0, timeout_err=0, busy=0.
- rst_n low takes effect immediately (asynchronous) and aborts any LOAD or COMPARE in flight. Release is synchronised externally.
- enable=1 sampled at edge 0 in IDLE gives WAIT from edge 1.
- temp_ready high at edge t in WAIT:
  - load high cycle t+1
  - compare_data high cycle t+2
  - WAIT on next channel from edge t+3
- Minimum 3 cycles per channel, so 3*NUM_CH per full sweep when all channels are ready.
- Timeout: with ready held low, timeout_err is high exactly TIMEOUT_CYCLES cycles after entering WAIT on that channel. ch_sel shows the next channel in the same cycle.
- load and compare_data are never high together. A LOAD is always followed by exactly one COMPARE.

## Configuration
- TEMP_SEQ_TIMEOUT_EN defined: watchdog counter and timeout_err present, behaviour as above.
- TEMP_SEQ_TIMEOUT_EN undefined: no counter logic. WAIT waits indefinitely for ready or enable=0. timeout_err is tied to 0.

## Test plan
All scenarios use NUM_CH=4, TIMEOUT_CYCLES=16, TEMP_SEQ_TIMEOUT_EN defined unless stated.
- Reset: rst_n low mid-LOAD -> load drops immediately, all outputs at reset values, ch_sel=0; after release with enable=1, WAIT on channel 0.
- Full sweep: temp_ready=4'b1111, enable=1 -> load pulses every 3 cycles on ch 0,1,2,3; sweep_done once with compare on ch 3; ch_sel wraps to 0.
- Timeout: temp_ready=4'b1101 -> ch 1 produces timeout_err 16 cycles after its WAIT entry, no load; ch_sel moves to 2; ch 2 and 3 serviced normally.
- Stop: enable dropped during LOAD on ch 2 -> COMPARE completes, state IDLE, ch_sel=3, busy=0. enable dropped in WAIT -> IDLE next edge with no load.
- Ignore non-selected ready: in WAIT on ch 0, pulse temp_ready[2] for one cycle only -> no load; ch 2 is later served only when its ready is high during its own WAIT.
- Macro off: TEMP_SEQ_TIMEOUT_EN undefined, temp_ready=0 for 100 cycles -> stays in WAIT on ch 0, timeout_err stays 0.

Source files
------------

// File: rtl/temp_seq_ctrl.sv
// Round-robin load/compare sequencer for NUM_CH temperature sensors.
// Define TEMP_SEQ_TIMEOUT_EN to build in the per-channel watchdog and timeout_err.
module temp_seq_ctrl #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         temp_ready,
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic                      load,
  output logic                      compare_data,
  output logic                      sweep_done,
  output logic                      timeout_err,
  output logic                      busy
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, WAIT, LOAD, COMPARE} state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;

  // Wrap explicitly so non-power-of-two channel counts never select a missing sensor.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    if (ch == CH_W'(NUM_CH - 1)) return '0;
    else                         return ch + 1'b1;
  endfunction

`ifdef TEMP_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Counter defaults to zero, so any path into WAIT starts a fresh watchdog window.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
`ifdef TEMP_SEQ_TIMEOUT_EN
    cnt_d   = '0;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT;
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (temp_ready[ch_q]) begin
          state_d = LOAD;
        end else begin
`ifdef TEMP_SEQ_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            ch_d  = next_ch(ch_q);
            tmo_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      LOAD: begin
        state_d = COMPARE;
      end
      COMPARE: begin
        ch_d    = next_ch(ch_q);
        state_d = enable ? WAIT : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ch_sel       = ch_q;
  assign load         = (state_q == LOAD);
  assign compare_data = (state_q == COMPARE);
  assign sweep_done   = (state_q == COMPARE) && (ch_q == CH_W'(NUM_CH - 1));
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_temp_seq_ctrl.sv
// Directed bench for temp_seq_ctrl (NUM_CH=4, TIMEOUT_CYCLES=16); watchdog scenarios
// run when TEMP_SEQ_TIMEOUT_EN is defined, the no-watchdog scenario otherwise.
module tb_temp_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] temp_ready;
  logic [1:0] ch_sel;
  logic       load;
  logic       compare_data;
  logic       sweep_done;
  logic       timeout_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  temp_seq_ctrl #(.NUM_CH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .temp_ready   (temp_ready),
    .ch_sel       (ch_sel),
    .load         (load),
    .compare_data (compare_data),
    .sweep_done   (sweep_done),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the DUT in IDLE, ch 0, positioned just after a falling edge.
  task automatic do_reset();
    rst_n      = 1'b0;
    enable     = 1'b0;
    temp_ready = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    enable     = 1'b0;
    temp_ready = 4'b0000;
    @(negedge clk);
    checks++; if (load !== 1'b0)         begin errors++; $display("FAIL rst_load got %0b exp 0", load); end
    checks++; if (compare_data !== 1'b0) begin errors++; $display("FAIL rst_cmp got %0b exp 0", compare_data); end
    checks++; if (sweep_done !== 1'b0)   begin errors++; $display("FAIL rst_sweep got %0b exp 0", sweep_done); end
    checks++; if (timeout_err !== 1'b0)  begin errors++; $display("FAIL rst_tmo got %0b exp 0", timeout_err); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (ch_sel !== 2'd0)       begin errors++; $display("FAIL rst_ch got %0d exp 0", ch_sel); end
    // Run into LOAD on ch 0, then reset mid-cycle.
    rst_n      = 1'b1;
    enable     = 1'b1;
    temp_ready = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    checks++; if (load !== 1'b1) begin errors++; $display("FAIL rst_pre_load got %0b exp 1", load); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (load !== 1'b0)   begin errors++; $display("FAIL rst_async_load got %0b exp 0", load); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_async_busy got %0b exp 0", busy); end
    checks++; if (ch_sel !== 2'd0) begin errors++; $display("FAIL rst_async_ch got %0d exp 0", ch_sel); end
    checks++; if (compare_data !== 1'b0) begin errors++; $display("FAIL rst_async_cmp got %0b exp 0", compare_data); end
    @(negedge clk);
    rst_n      = 1'b1;
    temp_ready = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL rst_rel_busy got %0b exp 1", busy); end
    checks++; if (ch_sel !== 2'd0) begin errors++; $display("FAIL rst_rel_ch got %0d exp 0", ch_sel); end
    checks++; if (load !== 1'b0)   begin errors++; $display("FAIL rst_rel_load got %0b exp 0", load); end
  endtask

  // Cycle 1 is WAIT ch0; from cycle 2 each channel k takes LOAD, COMPARE, WAIT(next).
  task automatic test_full_sweep();
    int sweeps;
    logic       e_load, e_cmp, e_sweep;
    logic [1:0] e_ch;
    sweeps = 0;
    do_reset();
    enable     = 1'b1;
    temp_ready = 4'b1111;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (i == 1) begin
        e_load = 0; e_cmp = 0; e_sweep = 0; e_ch = 2'd0;
      end else begin
        e_load  = ((i - 2) % 3 == 0);
        e_cmp   = ((i - 2) % 3 == 1);
        e_ch    = ((i - 2) % 3 == 2) ? 2'(((i - 2) / 3 + 1) % 4) : 2'((i - 2) / 3);
        e_sweep = e_cmp && ((i - 2) / 3 == 3);
      end
      if (sweep_done === 1'b1) sweeps++;
      checks++; if (load !== e_load)          begin errors++; $display("FAIL sweep_load c%0d got %0b exp %0b", i, load, e_load); end
      checks++; if (compare_data !== e_cmp)   begin errors++; $display("FAIL sweep_cmp c%0d got %0b exp %0b", i, compare_data, e_cmp); end
      checks++; if (sweep_done !== e_sweep)   begin errors++; $display("FAIL sweep_done c%0d got %0b exp %0b", i, sweep_done, e_sweep); end
      checks++; if (ch_sel !== e_ch)          begin errors++; $display("FAIL sweep_ch c%0d got %0d exp %0d", i, ch_sel, e_ch); end
      checks++; if (busy !== 1'b1)            begin errors++; $display("FAIL sweep_busy c%0d got %0b exp 1", i, busy); end
    end
    checks++; if (sweeps != 1) begin errors++; $display("FAIL sweep_count got %0d exp 1", sweeps); end
  endtask

`ifdef TEMP_SEQ_TIMEOUT_EN
  // Ch 1 enters WAIT at edge 4; timeout_err in cycle 20 with ch_sel already 2.
  task automatic test_timeout();
    do_reset();
    enable     = 1'b1;
    temp_ready = 4'b1101;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i >= 5 && i <= 19) begin
        checks++; if (load !== 1'b0)        begin errors++; $display("FAIL tmo_wait_load c%0d got %0b exp 0", i, load); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early c%0d got %0b exp 0", i, timeout_err); end
        checks++; if (ch_sel !== 2'd1)      begin errors++; $display("FAIL tmo_wait_ch c%0d got %0d exp 1", i, ch_sel); end
      end
      if (i == 20) begin
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_pulse got %0b exp 1", timeout_err); end
        checks++; if (ch_sel !== 2'd2)      begin errors++; $display("FAIL tmo_ch got %0d exp 2", ch_sel); end
        checks++; if (load !== 1'b0)        begin errors++; $display("FAIL tmo_load got %0b exp 0", load); end
      end
      if (i == 21) begin
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_one_cycle got %0b exp 0", timeout_err); end
        checks++; if (load !== 1'b1)        begin errors++; $display("FAIL tmo_ch2_load got %0b exp 1", load); end
        checks++; if (ch_sel !== 2'd2)      begin errors++; $display("FAIL tmo_ch2_sel got %0d exp 2", ch_sel); end
      end
      if (i == 24) begin
        checks++; if (load !== 1'b1)        begin errors++; $display("FAIL tmo_ch3_load got %0b exp 1", load); end
        checks++; if (ch_sel !== 2'd3)      begin errors++; $display("FAIL tmo_ch3_sel got %0d exp 3", ch_sel); end
      end
    end
  endtask
`else
  task automatic test_macro_off();
    do_reset();
    enable     = 1'b1;
    temp_ready = 4'b0000;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL off_tmo c%0d got %0b exp 0", i, timeout_err); end
      checks++; if (ch_sel !== 2'd0)      begin errors++; $display("FAIL off_ch c%0d got %0d exp 0", i, ch_sel); end
      checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL off_busy c%0d got %0b exp 1", i, busy); end
    end
  endtask
`endif

  task automatic test_stop();
    do_reset();
    enable     = 1'b1;
    temp_ready = 4'b1111;
    for (int i = 1; i <= 8; i++) @(negedge clk);
    checks++; if (load !== 1'b1 || ch_sel !== 2'd2) begin errors++; $display("FAIL stop_load_ch2 got load=%0b ch=%0d exp load=1 ch=2", load, ch_sel); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (compare_data !== 1'b1) begin errors++; $display("FAIL stop_cmp got %0b exp 1", compare_data); end
    @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL stop_idle_busy got %0b exp 0", busy); end
    checks++; if (ch_sel !== 2'd3) begin errors++; $display("FAIL stop_idle_ch got %0d exp 3", ch_sel); end
    @(negedge clk);
    checks++; if (load !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop_hold got load=%0b busy=%0b exp 0 0", load, busy); end
    enable     = 1'b1;
    temp_ready = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_rewait got %0b exp 1", busy); end
    enable     = 1'b0;
    temp_ready = 4'b1111;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_wait_idle got %0b exp 0", busy); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL stop_wait_load got %0b exp 0", load); end
    @(negedge clk);
    checks++; if (load !== 1'b0 || ch_sel !== 2'd3) begin errors++; $display("FAIL stop_after got load=%0b ch=%0d exp 0 3", load, ch_sel); end
  endtask

  task automatic test_ignore_ready();
    do_reset();
    enable     = 1'b1;
    temp_ready = 4'b0000;
    @(negedge clk);
    temp_ready = 4'b0100;
    @(negedge clk);
    checks++; if (load !== 1'b0 || ch_sel !== 2'd0) begin errors++; $display("FAIL ign_ch0 got load=%0b ch=%0d exp 0 0", load, ch_sel); end
    temp_ready = 4'b0000;
    for (int i = 3; i <= 5; i++) begin
      @(negedge clk);
      checks++; if (load !== 1'b0) begin errors++; $display("FAIL ign_idle_load c%0d got %0b exp 0", i, load); end
    end
    temp_ready = 4'b0001;
    @(negedge clk);
    checks++; if (load !== 1'b1 || ch_sel !== 2'd0) begin errors++; $display("FAIL ign_ch0_load got load=%0b ch=%0d exp 1 0", load, ch_sel); end
    @(negedge clk);
    temp_ready = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    checks++; if (load !== 1'b1 || ch_sel !== 2'd1) begin errors++; $display("FAIL ign_ch1_load got load=%0b ch=%0d exp 1 1", load, ch_sel); end
    @(negedge clk);
    temp_ready = 4'b0000;
    for (int i = 11; i <= 13; i++) begin
      @(negedge clk);
      checks++; if (load !== 1'b0 || ch_sel !== 2'd2) begin errors++; $display("FAIL ign_ch2_wait c%0d got load=%0b ch=%0d exp 0 2", i, load, ch_sel); end
    end
    temp_ready = 4'b0100;
    @(negedge clk);
    checks++; if (load !== 1'b1 || ch_sel !== 2'd2) begin errors++; $display("FAIL ign_ch2_load got load=%0b ch=%0d exp 1 2", load, ch_sel); end
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    temp_ready = 4'b0000;
    test_reset();
    test_full_sweep();
`ifdef TEMP_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_macro_off();
`endif
    test_stop();
    test_ignore_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
